// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide sequencer that owns HI/LO for the E stage.
// Results are computed from latched operands and committed on the last busy edge.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       op_reg, op_next;
  logic [31:0]      a_reg, a_next;
  logic [31:0]      b_reg, b_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] divisor, abs_a, abs_b, mag_q, mag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;

  assign a_sx   = {{32{a_reg[31]}}, a_reg};
  assign b_sx   = {{32{b_reg[31]}}, b_reg};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

  // Substitute 1 for a zero divisor so the dividers never see 0; the result is discarded anyway.
  assign divisor = (b_reg == 32'd0) ? 32'd1 : b_reg;
  assign abs_a   = a_reg[31]   ? (32'd0 - a_reg)   : a_reg;
  assign abs_b   = divisor[31] ? (32'd0 - divisor) : divisor;
  assign mag_q   = abs_a / abs_b;
  assign mag_r   = abs_a % abs_b;
  assign sdiv_q  = (a_reg[31] ^ divisor[31]) ? (32'd0 - mag_q) : mag_q;
  assign sdiv_r  = a_reg[31] ? (32'd0 - mag_r) : mag_r;
  assign udiv_q  = a_reg / divisor;
  assign udiv_r  = a_reg % divisor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= 2'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              op_next    = op[1:0];
              a_next     = rs_val;
              b_next     = rt_val;
              cnt_next   = op[1] ? DIV_LOAD : MULT_LOAD;
              state_next = BUSY;
            end
            3'd4:    hi_next = rs_val;
            3'd5:    lo_next = rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Any start arriving here is dropped on purpose.
        if (cnt_reg == '0) begin
          state_next = IDLE;
          case (op_reg)
            2'd0: {hi_next, lo_next} = prod_s;
            2'd1: {hi_next, lo_next} = prod_u;
            2'd2: if (b_reg != 32'd0) begin
              hi_next = sdiv_r;
              lo_next = sdiv_q;
            end
            default: if (b_reg != 32'd0) begin
              hi_next = udiv_r;
              lo_next = udiv_q;
            end
          endcase
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg == BUSY);
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  // mthi/mtlo land before the dependent instruction reaches E, so only ops 0-3 stall.
  assign md_stall = md_use_D & (busy | (start & ~op[2]));

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline; sits beside the ALU in the E stage.
- Accepts mult/multu/div/divu/mthi/mtlo from E and owns the HI/LO registers.
- Runs a fixed-latency busy phase and raises a stall request for any D-stage instruction that touches HI/LO while an operation is in flight or starting.
- The pipeline stall unit ORs md_stall into its existing stall term.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage md instruction valid this cycle.
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6/7 = no-op.
- rs_val  in  32  forwarded rs operand in E.
- rt_val  in  32  forwarded rt operand in E.
- md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_stall  out  1  stall request to pipeline.

Behaviour:
Reset (reset=0, asynchronous, any time including mid-operation):
- State IDLE, counter 0, busy=0, hi=0, lo=0.
- Pending result discarded.

States: IDLE, BUSY.

IDLE:
- op 0-3 with start=1 at edge t:
  - Latch rs_val, rt_val, op.
  - Load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES).
  - Go to BUSY.
  - busy=1 for exactly N cycles, starting the cycle after edge t.
- op 4 with start=1: hi<=rs_val at that edge; no busy.
- op 5 with start=1: lo<=rs_val at that edge; no busy.
- op 6/7, or start=0: no change.

BUSY:
- Counter decrements each edge.
- At the edge where counter==0: commit result to hi/lo, go to IDLE, busy drops.
- New hi/lo are visible in the first cycle with busy=0.
- Any start (any op) while BUSY is ignored; hi/lo are not written.

Arithmetic, on latched operands:
- mult: signed 64-bit product; hi=[63:32], lo=[31:0].
- multu: unsigned 64-bit product; hi=[63:32], lo=[31:0].
- div: lo=quotient, truncated toward zero; hi=remainder, with the sign of the dividend.
- divu: unsigned; lo=quotient, hi=remainder.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divisor 0 (div or divu): busy phase still runs the full DIV_CYCLES; hi/lo unchanged at commit.
- Result may be computed combinationally and registered at commit; only the commit timing is architectural.

md_stall (combinational):
- md_stall = md_use_D & (busy | (start & op<=3)).
- With start=1 and op 4/5, no stall (write lands before the D instruction reaches E).

Outputs:
- busy, hi, lo are registered outputs.
- md_stall is the only combinational output.

Test Plan:
- Signed multiply: mult, rs=0xFFFFFFFF, rt=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Unsigned multiply: multu, same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- Signed divide: div, rs=0xFFFFFFF9 (-7), rt=0x00000002 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide edge cases:
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - divu 7 / 0 with prior hi=0x11, lo=0x22 -> 10 busy cycles, hi=0x11, lo=0x22.
- Stall and ignore while busy:
  - md_use_D=1 during the start cycle and every busy cycle -> md_stall=1; md_stall=0 in the first cycle after busy drops.
  - mthi 0xABCD issued mid-busy -> ignored.
  - mtlo 0x1234 from IDLE -> lo=0x1234 next cycle, no busy, md_stall=0.
- Reset mid-operation: reset=0 asynchronously in busy cycle 3 of a mult -> busy, hi, lo=0 immediately without a clock edge; after release, no late commit occurs.
